shake_padder: RTL and testbench

// Byte-stream front end for the sponge core: accepts message bytes on a valid/ready stream and

---
 rtl/shake_padder.sv | 143 ++++++++++++++
 tb/tb_shake_padder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shake_padder.sv
`default_nettype none
// ============================================================================
// Module      : shake_padder
// Description : Byte-stream to RATE_WIDTH-bit block packer with SHAKE/SHA3
//               multi-rate padding (domain byte, then 0x80 in the last byte).
// Revision    : 1.0 - initial release
// ============================================================================
module shake_padder #(
  parameter int          RATE_WIDTH  = 1088,
  parameter logic [7:0]  DOMAIN_BYTE = 8'h1F
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  input  logic                  in_empty,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [RATE_WIDTH-1:0] blk_data,
  output logic                  blk_last,
  output logic [15:0]           blk_count,
  output logic [1:0]            debug_pad_fsm
);

  localparam int RATE_BYTES = RATE_WIDTH / 8;
  localparam int IDX_W      = $clog2(RATE_BYTES);
  localparam int PW         = $clog2(RATE_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_BYTES - 1);
  // Block emitted when the message ended exactly on a block boundary
  localparam logic [RATE_WIDTH-1:0] PAD_BLOCK =
    {DOMAIN_BYTE, {(RATE_WIDTH-16){1'b0}}, 8'h80};

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT      = 2'd1,
    EMIT_PAD  = 2'd2,
    EMIT_LAST = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RATE_WIDTH-1:0]  blk_buf_q, blk_buf_d;
  logic [15:0]            cnt_q, cnt_d;
  // Set after the final block of a message; clears the count on the next beat
  logic                   cnt_clr_q, cnt_clr_d;
  logic                   accept, handoff;
  logic [PW-1:0]          pos_cur, pos_nxt;

  assign in_ready      = (state_q == FILL) && !reset;
  assign blk_valid     = (state_q != FILL);
  assign blk_last      = (state_q == EMIT_LAST);
  assign blk_data      = blk_buf_q;
  assign blk_count     = cnt_q;
  assign debug_pad_fsm = state_q;

  assign accept  = in_valid && in_ready;
  assign handoff = blk_valid && blk_ready;

  // Bit positions of the current byte slot and the slot after it (byte 0 is MSB)
  assign pos_cur = PW'(8 * (RATE_BYTES - 1 - int'(idx_q)));
  assign pos_nxt = PW'(8 * (RATE_BYTES - 2 - int'(idx_q)));

  // State, index, buffer and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      idx_q     <= '0;
      blk_buf_q <= '0;
      cnt_q     <= '0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_buf_q <= blk_buf_d;
      cnt_q     <= cnt_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  // Next-state: byte packing and padding in FILL, block handoff in EMIT*
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_buf_d = blk_buf_q;
    cnt_d     = cnt_q;
    cnt_clr_d = cnt_clr_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_clr_q) begin
            cnt_d     = '0;
            cnt_clr_d = 1'b0;
          end
          if (in_last && in_empty) begin
            blk_buf_d[pos_cur +: 8] = DOMAIN_BYTE;
            blk_buf_d[7:0]          = blk_buf_d[7:0] | 8'h80;
            state_d                 = EMIT_LAST;
          end else begin
            blk_buf_d[pos_cur +: 8] = in_data;
            if (idx_q == LAST_IDX) begin
              // Full block; a message ending here needs a separate pad block
              state_d = in_last ? EMIT_PAD : EMIT;
            end else if (in_last) begin
              blk_buf_d[pos_nxt +: 8] = DOMAIN_BYTE;
              blk_buf_d[7:0]          = blk_buf_d[7:0] | 8'h80;
              state_d                 = EMIT_LAST;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      EMIT: begin
        if (handoff) begin
          cnt_d     = cnt_q + 16'd1;
          state_d   = FILL;
          idx_d     = '0;
          blk_buf_d = '0;
        end
      end
      EMIT_PAD: begin
        if (handoff) begin
          cnt_d     = cnt_q + 16'd1;
          blk_buf_d = PAD_BLOCK;
          state_d   = EMIT_LAST;
        end
      end
      default: begin
        if (handoff) begin
          cnt_d     = cnt_q + 16'd1;
          state_d   = FILL;
          idx_d     = '0;
          blk_buf_d = '0;
          cnt_clr_d = 1'b1;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shake_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_shake_padder
// Description : Directed self-checking bench for shake_padder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shake_padder;

  localparam int RW = 1088;
  localparam int RB = RW / 8;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_empty;
  logic          blk_valid;
  logic          blk_ready;
  logic [RW-1:0] blk_data;
  logic          blk_last;
  logic [15:0]   blk_count;
  logic [1:0]    debug_pad_fsm;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    eb [RB];
  logic [RW-1:0] exp_blk;

  shake_padder #(.RATE_WIDTH(RW), .DOMAIN_BYTE(8'h1F)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .blk_count    (blk_count),
    .debug_pad_fsm(debug_pad_fsm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_eb();
    for (int i = 0; i < RB; i++) eb[i] = 8'h00;
  endtask

  // Byte i of the block lives at bits [RW-1-8*i -: 8]
  task automatic pack_eb();
    for (int i = 0; i < RB; i++) exp_blk[RW-1-8*i -: 8] = eb[i];
  endtask

  task automatic check_block(input string tag, input logic exp_last);
    for (int c = 0; c < RW / 64; c++)
      check($sformatf("%s data%0d", tag, c), blk_data[64*c +: 64], exp_blk[64*c +: 64]);
    check({tag, " last"}, 64'(blk_last), 64'(exp_last));
    check({tag, " in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; in_empty = e;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic recv(input string tag, input logic exp_last);
    int n;
    n = 0;
    while (!blk_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 64'(blk_valid), 64'd1);
    check_block(tag, exp_last);
    blk_ready = 1'b1;
    @(posedge clk);
    #1 blk_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    in_empty = 1'b0; blk_ready = 1'b0;
    #2;
    check("in_ready in reset", 64'(in_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst blk_valid", 64'(blk_valid), 64'd0);
    check("rst blk_last", 64'(blk_last), 64'd0);
    check("rst blk_count", 64'(blk_count), 64'd0);
    check("rst fsm", 64'(debug_pad_fsm), 64'd0);
    check("rst data hi", blk_data[RW-1 -: 64], 64'd0);

    // 1) empty message
    send(8'hEE, 1'b1, 1'b1);
    clear_eb(); eb[0] = 8'h1F; eb[RB-1] = 8'h80; pack_eb();
    check("t1 fsm", 64'(debug_pad_fsm), 64'd3);
    check("t1 count before", 64'(blk_count), 64'd0);
    recv("t1", 1'b1);
    check("t1 count after", 64'(blk_count), 64'd1);
    check("t1 idle", 64'(blk_valid), 64'd0);

    // 2) "abc"
    send(8'h61, 1'b0, 1'b0);
    check("t2 count cleared", 64'(blk_count), 64'd0);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    clear_eb(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h1F;
    eb[RB-1] = 8'h80; pack_eb();
    recv("t2", 1'b1);
    check("t2 count after", 64'(blk_count), 64'd1);

    // 3) 135 bytes of 0xA5: domain byte merges with 0x80 in the last slot
    for (int i = 0; i < RB - 1; i++) send(8'hA5, (i == RB - 2), 1'b0);
    for (int i = 0; i < RB - 1; i++) eb[i] = 8'hA5;
    eb[RB-1] = 8'h9F; pack_eb();
    recv("t3", 1'b1);

    // 4) 136 zero bytes: full data block, then a pad-only block
    for (int i = 0; i < RB; i++) send(8'h00, (i == RB - 1), 1'b0);
    clear_eb(); pack_eb();
    check("t4 fsm pad", 64'(debug_pad_fsm), 64'd2);
    recv("t4 b1", 1'b0);
    check("t4 count mid", 64'(blk_count), 64'd1);
    clear_eb(); eb[0] = 8'h1F; eb[RB-1] = 8'h80; pack_eb();
    recv("t4 b2", 1'b1);
    check("t4 count end", 64'(blk_count), 64'd2);

    // 5) backpressure with a beat stalled at the input
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    clear_eb(); eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h1F; eb[RB-1] = 8'h80;
    pack_eb();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1; in_empty = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t5 hold%0d hi", k), blk_data[RW-1 -: 64], exp_blk[RW-1 -: 64]);
      check($sformatf("t5 hold%0d lo", k), blk_data[63:0], exp_blk[63:0]);
      check($sformatf("t5 hold%0d last", k), 64'(blk_last), 64'd1);
      check($sformatf("t5 hold%0d rdy", k), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    recv("t5 b1", 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
    clear_eb(); eb[0] = 8'h77; eb[1] = 8'h1F; eb[RB-1] = 8'h80; pack_eb();
    recv("t5 b2", 1'b1);

    // 6) reset in the middle of a message, then "abc"
    for (int i = 0; i < 50; i++) send(8'h3C, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6 in_ready", 64'(in_ready), 64'd0);
    check("t6 fsm", 64'(debug_pad_fsm), 64'd0);
    check("t6 data hi", blk_data[RW-1 -: 64], 64'd0);
    check("t6 valid", 64'(blk_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    clear_eb(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h1F;
    eb[RB-1] = 8'h80; pack_eb();
    recv("t6", 1'b1);
    check("t6 count", 64'(blk_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
